// File: rtl/can_tx_arbiter.sv
// CAN transmit arbiter: scans NUM_MB mailboxes, picks the lowest standard ID and
// writes that frame into the TX FIFO, acking the winning mailbox for one cycle.
module can_tx_arbiter #(
  parameter int unsigned NUM_MB = 4,
  parameter int unsigned IDX_W  = $clog2(NUM_MB)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [NUM_MB-1:0]     i_mb_req,
  input  logic [NUM_MB*128-1:0] i_mb_data,
  output logic [NUM_MB-1:0]     o_mb_ack,
  input  logic                  i_fifo_full,
  input  logic                  i_fifo_overflow,
  output logic                  o_fifo_w_en,
  output logic [127:0]          o_fifo_w_data,
  output logic                  o_busy,
  output logic [IDX_W-1:0]      o_grant_idx,
  output logic [15:0]           o_frame_cnt,
  input  logic                  i_clr_err,
  output logic                  o_err_overflow
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StPush = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [10:0]      best_id_q, best_id_d;
  logic             best_vld_q, best_vld_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;

  logic [127:0] frame [NUM_MB];
  logic [10:0]  scan_id;
  logic         take;
  logic         last_scan;

  for (genvar k = 0; k < NUM_MB; k++) begin : g_frame
    assign frame[k] = i_mb_data[k*128 +: 128];
  end

  assign scan_id   = frame[scan_idx_q][127:117];
  assign last_scan = (scan_idx_q == IDX_W'(NUM_MB - 1));

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    best_idx_d  = best_idx_q;
    best_id_d   = best_id_q;
    best_vld_d  = best_vld_q;
    grant_idx_d = grant_idx_q;
    frame_cnt_d = frame_cnt_q;
    o_fifo_w_en = 1'b0;
    o_mb_ack    = '0;
    take        = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_enable && (|i_mb_req) && !i_fifo_full) begin
          state_d    = StScan;
          scan_idx_d = '0;
          best_vld_d = 1'b0;
        end
      end
      StScan: begin
        // Strict compare keeps the lower index on equal IDs.
        take = i_mb_req[scan_idx_q] && (!best_vld_q || (scan_id < best_id_q));
        if (take) begin
          best_idx_d = scan_idx_q;
          best_id_d  = scan_id;
          best_vld_d = 1'b1;
        end
        if (last_scan) begin
          state_d = (take || best_vld_q) ? StPush : StIdle;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      StPush: begin
        // Withdrawal beats the full stall.
        if (!i_mb_req[best_idx_q]) begin
          state_d = StIdle;
        end else if (!i_fifo_full) begin
          o_fifo_w_en          = 1'b1;
          o_mb_ack[best_idx_q] = 1'b1;
          grant_idx_d          = best_idx_q;
          frame_cnt_d          = frame_cnt_q + 16'd1;
          state_d              = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (i_fifo_overflow) begin
      err_d = 1'b1;
    end else if (i_clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      scan_idx_q  <= '0;
      best_idx_q  <= '0;
      best_id_q   <= '0;
      best_vld_q  <= 1'b0;
      grant_idx_q <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      best_idx_q  <= best_idx_d;
      best_id_q   <= best_id_d;
      best_vld_q  <= best_vld_d;
      grant_idx_q <= grant_idx_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign o_fifo_w_data  = frame[best_idx_q];
  assign o_busy         = (state_q != StIdle);
  assign o_grant_idx    = grant_idx_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_err_overflow = err_q;

endmodule
